mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning memory address width.
REQ-002 SHALL have parameter DW, default 16, meaning memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied debug cycles before debug wins.
REQ-004 SHALL have port Clk  in  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports cpu_req/cpu_we  in  1 each  CPU access request / write enable (from multicycle controller).
REQ-007 SHALL have ports cpu_addr  in  AW and cpu_wdata  in  DW  CPU address / write data.
REQ-008 SHALL have ports cpu_gnt  out  1, cpu_stall  out  1 (=cpu_req & ~cpu_gnt), cpu_rvalid  out  1, cpu_rdata  out  DW.
REQ-009 SHALL have ports dbg_req/dbg_we  in  1 each, dbg_addr  in  AW, dbg_wdata  in  DW  debug/loader port.
REQ-010 SHALL have ports dbg_gnt  out  1, dbg_rvalid  out  1, dbg_rdata  out  DW.
REQ-011 SHALL have ports dbg_halt  in  1 (request CPU freeze) and halt_ack  out  1 (CPU frozen).
REQ-012 SHALL have ports mem_en/mem_we  out  1 each, mem_addr  out  AW, mem_wdata  out  DW, mem_rdata  in  DW  (single-port synchronous RAM, read data one cycle after mem_en).

Function
REQ-013 SHALL issue at most one grant per cycle; a grant drives mem_en=1, mem_we/addr/wdata from the granted port in the same cycle (combinational).
REQ-014 SHALL keep requests pending until granted; the requester holds req/we/addr/wdata stable until its gnt.
REQ-015 SHALL assert <port>_rvalid exactly one cycle after a granted read (we=0), with <port>_rdata=mem_rdata; rdata SHALL be 0 when rvalid=0; writes produce no rvalid.
REQ-016 SHALL accept a new grant every cycle (back-to-back) regardless of a response in flight.
REQ-017 SHALL give CPU priority on simultaneous requests, except debug wins when starve_cnt==STARVE_LIMIT.
REQ-018 SHALL increment starve_cnt when dbg_req & ~dbg_gnt, saturate at STARVE_LIMIT, and clear it on dbg_gnt or dbg_req=0.
REQ-019 SHALL implement halt FSM RUN/DRAIN/HALTED: RUN->DRAIN when dbg_halt=1; DRAIN->HALTED when no CPU read response is pending; HALTED->RUN when dbg_halt=0; DRAIN->RUN if dbg_halt drops first.
REQ-020 SHALL grant CPU only in RUN; debug is grantable in all states; halt_ack=1 only in HALTED.
REQ-021 SHALL, with no request, drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Reset
REQ-022 SHALL, while Reset=0, force FSM=RUN, starve_cnt=0, response-pending flags=0, and therefore all gnt/rvalid/halt_ack/mem_en/mem_we=0 and rdata=0.
REQ-023 SHALL drop any response in flight when reset asserts mid-operation; no rvalid is produced after reset release for a pre-reset grant.

Structure
REQ-024 SHALL place the halt-FSM state encoding and default AW/DW/STARVE_LIMIT constants in shared package mem_arb_pkg.
REQ-025 SHALL be a single module; no sub-module is required.

Verification
REQ-026 Bench SHALL check: CPU read addr 0x0010 alone, RAM[0x10]=0xBEEF -> cpu_gnt cycle N, cpu_rvalid=1 with cpu_rdata=0xBEEF at N+1, dbg_rvalid=0.
REQ-027 Bench SHALL check: cpu_req and dbg_req held high continuously -> CPU granted 4 cycles, debug granted on the 5th, pattern repeats (4:1).
REQ-028 Bench SHALL check: debug write 0x1234 to 0x0020 then CPU read 0x0020 back-to-back -> cpu_rdata=0x1234 two cycles after the debug grant.
REQ-029 Bench SHALL check: dbg_halt=1 in the same cycle a CPU read is granted -> DRAIN one cycle, cpu_rvalid delivered, HALTED next, halt_ack=1, cpu_stall=1 while cpu_req=1.
REQ-030 Bench SHALL check: Reset pulsed low for one cycle during a pending CPU read -> all outputs 0 immediately, no cpu_rvalid after release, FSM=RUN.
REQ-031 Bench SHALL check: dbg_halt released in HALTED with cpu_req=1 -> halt_ack=0 and cpu_gnt=1 on the following cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and halt-FSM encoding for the CPU/debug memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW           = 16;
  localparam int DEF_DW           = 16;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one synchronous single-port RAM,
// with starvation protection for debug and a halt handshake that freezes the CPU.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          Clk,
  input  logic          Reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  input  logic          dbg_halt,
  output logic          halt_ack,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  halt_state_e   state_q;
  logic          halt_ack_q;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          cpu_rd_pend_q, cpu_rd_pend_d;
  logic          dbg_rd_pend_q, dbg_rd_pend_d;

  logic          cpu_elig;
  logic          dbg_win;

  // Grants are gated by Reset so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_elig = Reset & cpu_req & (state_q == ST_RUN);
    dbg_win  = Reset & dbg_req & (~cpu_elig | (starve_cnt_q == STARVE_MAX));
  end

  assign dbg_gnt   = dbg_win;
  assign cpu_gnt   = cpu_elig & ~dbg_win;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign halt_ack  = halt_ack_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    cpu_rd_pend_d = cpu_gnt & ~cpu_we;
    dbg_rd_pend_d = dbg_gnt & ~dbg_we;
    starve_cnt_d  = '0;
    if (dbg_req && !dbg_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + SW'(1);
    end
  end

  assign cpu_rvalid = cpu_rd_pend_q;
  assign dbg_rvalid = dbg_rd_pend_q;
  assign cpu_rdata  = cpu_rd_pend_q ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rd_pend_q ? mem_rdata : '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starve_cnt_q  <= '0;
      cpu_rd_pend_q <= 1'b0;
      dbg_rd_pend_q <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      dbg_rd_pend_q <= dbg_rd_pend_d;
    end
  end

  // Halt FSM. DRAIN waits until no CPU read will still be outstanding after this edge;
  // since the CPU is never granted outside RUN, that is normally a single cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      halt_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dbg_halt) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!dbg_halt) begin
            state_q <= ST_RUN;
          end else if (!cpu_rd_pend_d) begin
            state_q    <= ST_HALTED;
            halt_ack_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!dbg_halt) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          halt_ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
